// File: rtl/bvh_node_server_pkg.sv
// Shared BVH typedefs for the node server and its requesters.
// Holds the node/leaf records, index width and port count.
package bvh_node_server_pkg;

    localparam int BVH_NODE_INDEX_WIDTH  = 9;
    localparam int BVH_NODE_SERVER_PORTS = 2;

    typedef struct packed {
        logic [15:0] bound_min;
        logic [15:0] bound_max;
        logic [8:0]  left;
        logic [8:0]  right;
        logic        is_leaf;
    } BVH_Node;

    typedef struct packed {
        logic [23:0] prim_base;
        logic [7:0]  prim_count;
    } BVH_Leaf;

    localparam int BVH_ENTRY_W = $bits(BVH_Node) + 2 * $bits(BVH_Leaf);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } port_state_e;

endpackage

// File: rtl/bvh_node_server_if.sv
// Request/response bundle between traversal units and the node server.
// Index 0 is the raster port, index 1 the shadow port.
interface bvh_node_server_if;
    import bvh_node_server_pkg::*;

    logic [1:0]                      req_valid;
    logic [1:0]                      req_ready;
    logic [BVH_NODE_INDEX_WIDTH-1:0] req_node_index [2];
    logic [1:0]                      rsp_valid;
    logic [1:0]                      rsp_ready;
    BVH_Node                         rsp_node [2];
    BVH_Leaf                         rsp_leaf [2][2];
    logic [1:0]                      rsp_err;

    modport master (
        output req_valid, req_node_index, rsp_ready,
        input  req_ready, rsp_valid, rsp_node, rsp_leaf, rsp_err
    );

    modport slave (
        input  req_valid, req_node_index, rsp_ready,
        output req_ready, rsp_valid, rsp_node, rsp_leaf, rsp_err
    );

endinterface

// File: rtl/bvh_node_server_table_ram.sv
// Simple dual-port table RAM: one write, one read, read-first,
// registered read data.
module bvh_table_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end

endmodule

// File: rtl/bvh_node_server.sv
// BVH node/leaf responder: two round-robin requester ports on one RAM read.
// Define BVH_SERVER_MERGE_EN to serve equal simultaneous indices with one read.
module bvh_node_server
    import bvh_node_server_pkg::*;
#(
    parameter int NODE_DEPTH = 256
) (
    input  logic                            clk,
    input  logic                            resetn,
    bvh_node_server_if.slave                bus,
    input  logic                            wr_en,
    input  logic [BVH_NODE_INDEX_WIDTH-1:0] wr_addr,
    input  BVH_Node                         wr_node,
    input  BVH_Leaf                         wr_leaf [2]
);

    localparam int W   = BVH_NODE_INDEX_WIDTH;
    localparam int RAW = (NODE_DEPTH > 1) ? $clog2(NODE_DEPTH) : 1;
    localparam logic [W:0] DEPTH_L = (W + 1)'(NODE_DEPTH);

    function automatic logic in_range(input logic [W-1:0] idx);
        return {1'b0, idx} < DEPTH_L;
    endfunction

    port_state_e state_q [2];
    port_state_e state_d [2];
    logic [1:0]  elig;
    logic [1:0]  gnt;
    logic [1:0]  pend_err;
    logic [1:0]  rsp_err_q;
    logic        rr_q;
    logic        rr_d;
    logic        merge;
    logic        rd_en;
    logic [W-1:0] rd_idx;
    logic [BVH_ENTRY_W-1:0] rd_data;
    BVH_Node     rd_node;
    BVH_Leaf     rd_leaf0;
    BVH_Leaf     rd_leaf1;
    BVH_Node     node_q [2];
    BVH_Leaf     leaf_q [2][2];

    assign {rd_node, rd_leaf1, rd_leaf0} = rd_data;

    bvh_table_ram #(
        .DEPTH (NODE_DEPTH),
        .WIDTH (BVH_ENTRY_W),
        .AW    (RAW)
    ) u_ram (
        .clk (clk),
        .we  (wr_en && in_range(wr_addr)),
        .wa  (wr_addr[RAW-1:0]),
        .wd  ({wr_node, wr_leaf[1], wr_leaf[0]}),
        .re  (rd_en),
        .ra  (rd_idx[RAW-1:0]),
        .rd  (rd_data)
    );

    // Writes win the cycle; the pointer names the winner when both contend.
    always_comb begin
        elig[0] = bus.req_valid[0] && (state_q[0] == ST_IDLE);
        elig[1] = bus.req_valid[1] && (state_q[1] == ST_IDLE);
`ifdef BVH_SERVER_MERGE_EN
        merge = (&elig) &&
                (bus.req_node_index[0] == bus.req_node_index[1]);
`else
        merge = 1'b0;
`endif
        gnt[0] = !resetn && !wr_en && elig[0] &&
                 (!elig[1] || !rr_q || merge);
        gnt[1] = !resetn && !wr_en && elig[1] &&
                 (!elig[0] || rr_q || merge);
        rr_d   = rr_q ^ ((&elig) && !wr_en && !merge);
        rd_idx = gnt[0] ? bus.req_node_index[0]
                        : bus.req_node_index[1];
        rd_en  = (|gnt) && in_range(rd_idx);
        bus.req_ready = gnt;
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            state_d[k] = state_q[k];
            unique case (state_q[k])
                ST_IDLE: if (gnt[k]) state_d[k] = ST_WAIT;
                ST_WAIT: state_d[k] = ST_RESP;
                ST_RESP: if (bus.rsp_ready[k]) state_d[k] = ST_IDLE;
                default: state_d[k] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            rr_q      <= 1'b0;
            pend_err  <= '0;
            rsp_err_q <= '0;
            for (int k = 0; k < 2; k++) begin
                state_q[k]   <= ST_IDLE;
                node_q[k]    <= '0;
                leaf_q[k][0] <= '0;
                leaf_q[k][1] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                if (gnt[k])
                    pend_err[k] <= !in_range(bus.req_node_index[k]);
                // RAM data for this port's grant is valid only here.
                if (state_q[k] == ST_WAIT) begin
                    rsp_err_q[k] <= pend_err[k];
                    node_q[k]    <= pend_err[k] ? '0 : rd_node;
                    leaf_q[k][0] <= pend_err[k] ? '0 : rd_leaf0;
                    leaf_q[k][1] <= pend_err[k] ? '0 : rd_leaf1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bus.rsp_valid[k]   = (state_q[k] == ST_RESP);
            bus.rsp_node[k]    = node_q[k];
            bus.rsp_leaf[k][0] = leaf_q[k][0];
            bus.rsp_leaf[k][1] = leaf_q[k][1];
        end
        bus.rsp_err = rsp_err_q;
    end

endmodule

// File: tb/tb_bvh_node_server.sv
// Randomised scoreboard bench for bvh_node_server against a table model.
// Honours BVH_SERVER_MERGE_EN when the build defines it.
module tb_bvh_node_server;
    import bvh_node_server_pkg::*;

    localparam int DEPTH = 256;
    localparam int W     = BVH_NODE_INDEX_WIDTH;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         wr_en;
    logic [W-1:0] wr_addr;
    BVH_Node      wr_node;
    BVH_Leaf      wr_leaf [2];

    bvh_node_server_if bus ();

    bvh_node_server #(.NODE_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_node (wr_node),
        .wr_leaf (wr_leaf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int      port;
        BVH_Node n;
        BVH_Leaf l0;
        BVH_Leaf l1;
        logic    err;
        int      due;
        logic    shown;
    } exp_t;

    exp_t    sb [$];
    BVH_Node m_node  [DEPTH];
    BVH_Leaf m_leaf0 [DEPTH];
    BVH_Leaf m_leaf1 [DEPTH];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cnt [2] = '{0, 0};
    int   hs_cyc [2] = '{0, 0};
    logic busy [2] = '{1'b0, 1'b0};
    logic ptr = 1'b0;
    logic rst_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int find(input int k);
        foreach (sb[i]) if (sb[i].port == k) return i;
        return -1;
    endfunction

    function automatic BVH_Node rnode();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[$bits(BVH_Node)-1:0];
    endfunction

    // Monitor: decides who should be granted from the arbitration rules,
    // queues expected responses at handshake, checks responses as shown.
    always @(negedge clk) begin
        logic [1:0] el;
        logic [1:0] er;
        logic       mg;
        int         i;
        exp_t       e;
        cyc++;
        if (resetn) begin
            if (rst_prev) begin
                chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
                chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
                chk("rst_rsp_node", 64'(bus.rsp_node[0]), 64'd0);
                chk("rst_rsp_leaf", 64'(bus.rsp_leaf[1][1]), 64'd0);
            end
            sb.delete();
            busy[0]  = 1'b0;
            busy[1]  = 1'b0;
            ptr      = 1'b0;
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            el[0] = bus.req_valid[0] && !busy[0];
            el[1] = bus.req_valid[1] && !busy[1];
            mg = 1'b0;
`ifdef BVH_SERVER_MERGE_EN
            mg = (el == 2'b11) &&
                 (bus.req_node_index[0] == bus.req_node_index[1]);
`endif
            er = 2'b00;
            if (!wr_en) begin
                if (el != 2'b11) er = el;
                else if (mg)     er = 2'b11;
                else             er[ptr] = 1'b1;
            end
            chk("req_ready", 64'(bus.req_ready), 64'(er));
            for (int k = 0; k < 2; k++) begin
                if (bus.req_valid[k] && bus.req_ready[k]) begin
                    e.port  = k;
                    e.err   = int'(bus.req_node_index[k]) >= DEPTH;
                    e.n     = '0;
                    e.l0    = '0;
                    e.l1    = '0;
                    if (!e.err) begin
                        e.n  = m_node[int'(bus.req_node_index[k])];
                        e.l0 = m_leaf0[int'(bus.req_node_index[k])];
                        e.l1 = m_leaf1[int'(bus.req_node_index[k])];
                    end
                    e.due   = cyc + 2;
                    e.shown = 1'b0;
                    sb.push_back(e);
                    hs_cnt[k]++;
                    hs_cyc[k] = cyc;
                    busy[k] = 1'b1;
                end
            end
            if (el == 2'b11 && !wr_en && !mg) ptr = !ptr;
            for (int k = 0; k < 2; k++) begin
                i = find(k);
                if (i >= 0 && cyc == sb[i].due)
                    chk("rsp_on_time", 64'(bus.rsp_valid[k]), 64'd1);
                if (bus.rsp_valid[k]) begin
                    if (i < 0) begin
                        chk("rsp_spurious", 64'd1, 64'd0);
                    end else begin
                        if (!sb[i].shown) begin
                            chk("rsp_latency", 64'(cyc), 64'(sb[i].due));
                            sb[i].shown = 1'b1;
                        end
                        chk("rsp_node", 64'(bus.rsp_node[k]), 64'(sb[i].n));
                        chk("rsp_leaf0", 64'(bus.rsp_leaf[k][0]), 64'(sb[i].l0));
                        chk("rsp_leaf1", 64'(bus.rsp_leaf[k][1]), 64'(sb[i].l1));
                        chk("rsp_err", 64'(bus.rsp_err[k]), 64'(sb[i].err));
                        if (bus.rsp_ready[k]) begin
                            sb.delete(i);
                            busy[k] = 1'b0;
                        end
                    end
                end
            end
            if (wr_en && int'(wr_addr) < DEPTH) begin
                m_node[int'(wr_addr)]  = wr_node;
                m_leaf0[int'(wr_addr)] = wr_leaf[0];
                m_leaf1[int'(wr_addr)] = wr_leaf[1];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input BVH_Node n,
                      input BVH_Leaf l0, input BVH_Leaf l1);
        wr_en = 1'b1;
        wr_addr = W'(a);
        wr_node = n;
        wr_leaf[0] = l0;
        wr_leaf[1] = l1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic req(input int k, input int idx);
        int s;
        s = hs_cnt[k];
        bus.req_valid[k] = 1'b1;
        bus.req_node_index[k] = W'(idx);
        for (int t = 0; t < 40; t++) begin
            tick();
            if (hs_cnt[k] != s) break;
        end
        bus.req_valid[k] = 1'b0;
        chk("req_handshake", 64'(hs_cnt[k] != s), 64'd1);
    endtask

    task automatic wait_both(input int s0, input int s1);
        for (int t = 0; t < 40; t++) begin
            tick();
            if (hs_cnt[0] != s0) bus.req_valid[0] = 1'b0;
            if (hs_cnt[1] != s1) bus.req_valid[1] = 1'b0;
            if (hs_cnt[0] != s0 && hs_cnt[1] != s1) break;
        end
        bus.req_valid = 2'b00;
        chk("pair_handshake",
            64'(hs_cnt[0] != s0 && hs_cnt[1] != s1), 64'd1);
    endtask

    task automatic req2(input int i0, input int i1);
        int s0;
        int s1;
        s0 = hs_cnt[0];
        s1 = hs_cnt[1];
        bus.req_valid = 2'b11;
        bus.req_node_index[0] = W'(i0);
        bus.req_node_index[1] = W'(i1);
        wait_both(s0, s1);
    endtask

    task automatic drain();
        bus.rsp_ready = 2'b11;
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int s1;
        int d;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        bus.req_node_index[0] = '0;
        bus.req_node_index[1] = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_node = '0;
        wr_leaf[0] = '0;
        wr_leaf[1] = '0;
        repeat (4) tick();
        resetn = 1'b0;

        for (int a = 0; a < DEPTH; a++)
            wr(a, rnode(), BVH_Leaf'($urandom), BVH_Leaf'($urandom));
        wr(5, BVH_Node'(51'h2A5A50F0F3C3C),
           BVH_Leaf'(32'hA1A2A3A4), BVH_Leaf'(32'hB1B2B3B4));

        req(0, 5);
        drain();

        req2(3, 7);
        drain();
        chk("contend_p0_first", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
        req2(3, 7);
        drain();
        chk("contend_p1_first", 64'(hs_cyc[0] - hs_cyc[1]), 64'd1);

        bus.rsp_ready[1] = 1'b0;
        req(1, 40);
        bus.req_valid[1] = 1'b1;
        bus.req_node_index[1] = W'(41);
        repeat (10) tick();
        chk("bp_held", 64'(bus.rsp_valid[1]), 64'd1);
        s1 = hs_cnt[1];
        bus.rsp_ready[1] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (hs_cnt[1] != s1) break;
        end
        bus.req_valid[1] = 1'b0;
        chk("bp_release", 64'(hs_cnt[1] - s1), 64'd1);
        drain();

        req(0, DEPTH);
        req(0, DEPTH - 1);
        drain();

        s0 = hs_cnt[0];
        s1 = hs_cnt[1];
        bus.req_valid = 2'b11;
        bus.req_node_index[0] = W'(9);
        bus.req_node_index[1] = W'(9);
        wr_en = 1'b1;
        wr_addr = W'(9);
        wr_node = rnode();
        wr_leaf[0] = BVH_Leaf'($urandom);
        wr_leaf[1] = BVH_Leaf'($urandom);
        tick();
        wr_en = 1'b0;
        chk("collide_no_grant", 64'(hs_cnt[0] + hs_cnt[1] - s0 - s1), 64'd0);
        wait_both(s0, s1);
        drain();
        req(0, 9);
        wr(9, rnode(), BVH_Leaf'($urandom), BVH_Leaf'($urandom));
        drain();

        req2(12, 12);
        drain();
`ifdef BVH_SERVER_MERGE_EN
        chk("merge_same_cycle", 64'(hs_cyc[0]), 64'(hs_cyc[1]));
`else
        d = hs_cyc[0] - hs_cyc[1];
        chk("equal_idx_serial", 64'(d == 1 || d == -1), 64'd1);
`endif

        req(0, 20);
        resetn = 1'b1;
        tick();
        tick();
        resetn = 1'b0;
        repeat (4) tick();
        chk("rst_discard", 64'(bus.rsp_valid), 64'd0);
        req2(3, 7);
        drain();
        chk("rst_ptr_zero", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);

        for (int t = 0; t < 600; t++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 9) == 0)
                    bus.req_node_index[k] = W'(DEPTH + $urandom_range(0, 255));
                else
                    bus.req_node_index[k] = W'($urandom_range(0, DEPTH - 1));
            end
            if ($urandom_range(0, 4) == 0)
                bus.req_node_index[1] = bus.req_node_index[0];
            bus.rsp_ready = 2'($urandom_range(0, 3));
            wr_en = ($urandom_range(0, 9) == 0);
            wr_addr = W'($urandom_range(0, DEPTH + 15));
            wr_node = rnode();
            wr_leaf[0] = BVH_Leaf'($urandom);
            wr_leaf[1] = BVH_Leaf'($urandom);
            tick();
        end
        bus.req_valid = 2'b00;
        wr_en = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bvh_node_server.md
# bvh_node_server

BVH memory responder serving the node/leaf fetch requests that the ray traversal units (raster and shadow stages) issue. It holds the BVH node and leaf tables in on-chip RAM, arbitrates two requester ports onto one read path, and returns a `BVH_Node` plus its two `BVH_Leaf` entries per request. A host write port loads the tables before rendering.

## Interface
- `NODE_DEPTH`, default 256: number of node/leaf entries; must be ≤ 2^`BVH_NODE_INDEX_WIDTH`.
- `clk` in 1: single clock.
- `resetn` in 1: synchronous reset, active-high (1 = reset).
- `req_valid[2]` in 1 each: request valid. Port 0 is raster, port 1 is shadow.
- `req_ready[2]` out 1 each: request accepted when valid & ready.
- `req_node_index[2]` in `BVH_NODE_INDEX_WIDTH` each: node to fetch.
- `rsp_valid[2]` out 1 each: response valid; held until accepted.
- `rsp_ready[2]` in 1 each: requester consumes the response.
- `rsp_node[2]` out `BVH_Node` each: fetched node.
- `rsp_leaf[2][2]` out `BVH_Leaf`: fetched leaf pair.
- `rsp_err[2]` out 1 each: the index was ≥ `NODE_DEPTH`.
- `wr_en` in 1: table write strobe.
- `wr_addr` in `BVH_NODE_INDEX_WIDTH`: write address.
- `wr_node` in `BVH_Node`: node data to write.
- `wr_leaf[2]` in `BVH_Leaf`: leaf data to write.

## Operation
- Per-port FSM states:
  - IDLE: `req_ready` may be high.
  - WAIT: read in flight.
  - RESP: `rsp_valid` = 1.
- Transitions:
  - IDLE → WAIT on handshake.
  - WAIT → RESP after the read completes.
  - RESP → IDLE on `rsp_ready`.
- Each port has at most 1 outstanding request.
- Arbiter:
  - Single RAM read port, shared by both requester ports.
  - `req_ready[k]` = port k in IDLE, `wr_en` = 0, and port k wins arbitration.
  - A port wins if it is the only requester, or if both request and the round-robin pointer names it.
  - The pointer flips after every cycle in which both ports requested and one was granted.
  - Reset value of the pointer is 0.
- Write priority: when `wr_en` = 1, no request is granted that cycle.
- Read/write collision on the same address: the RAM is read-first. A read already in flight returns the old data.
- Out-of-range index (≥ `NODE_DEPTH`): RAM is not read; the response carries all-zero node/leaf with `rsp_err` = 1.
- `rsp_*` outputs are registered and stable while in RESP.
- Reset mid-operation: every FSM returns to IDLE and in-flight reads are discarded. RAM contents are not cleared.
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_err` = 0, `rsp_node`/`rsp_leaf` = 0.

## Timing
- Handshake at edge T:
  - RAM address registered at T.
  - RAM data registered at T+1.
  - `rsp_valid` high in cycle T+2 (latency 2).
- Back-to-back throughput per port is one request per 3 cycles when `rsp_ready` is held at 1 (response consumed in the first RESP cycle).
- Aggregate throughput is one grant per cycle across both ports.
- `req_ready` depends combinationally on both `req_valid` and on `wr_en`. Requesters must not make `req_valid` depend on `req_ready`.
- `rsp_valid` never drops without `rsp_ready`.

## Configuration
- `BVH_SERVER_MERGE_EN` defined:
  - If both ports are IDLE, both are valid, `wr_en` = 0, and the indices are equal, both are granted in the same cycle.
  - One RAM read serves both ports; both responses appear at T+2.
  - The round-robin pointer is unchanged.
- Undefined: equal indices are arbitrated normally; the second port is granted at T+1 at the earliest.

## Structure
- Shared package (existing BVH typedef header): `BVH_Node`, `BVH_Leaf`, `BVH_NODE_INDEX_WIDTH`, plus a new `BVH_NODE_SERVER_PORTS` = 2 constant.
- Sub-module `bvh_table_ram`: simple dual-port RAM (1 write, 1 read, read-first, registered output) with width `$bits(BVH_Node)` + 2×`$bits(BVH_Leaf)`. Instantiated once; arbiter and per-port FSMs live in the top.

## Test plan
- Load: write index 5 with node/leaf pattern A. Port 0 requests 5 at T → `rsp_valid[0]` at T+2 with pattern A, `rsp_err` = 0.
- Contention: both ports request distinct indices 3 and 7 in the same cycle after reset → port 0 granted first and port 1 granted the next cycle. Repeat → port 1 granted first.
- Backpressure: hold `rsp_ready[1]` = 0 for 10 cycles → response stable throughout, `req_ready[1]` = 0 throughout, releases on `rsp_ready`.
- Boundary: request index `NODE_DEPTH` → zero data with `rsp_err` = 1. Request `NODE_DEPTH`−1 → valid data.
- Write collision: `wr_en` on index 9 in the same cycle as both `req_valid` → no grant that cycle. A read of 9 granted the cycle before the write returns the old data.
- With `BVH_SERVER_MERGE_EN`: both ports request index 12 simultaneously → both granted the same cycle, both `rsp_valid` at T+2 with identical data.
